// File: rtl/scanner_pkg.sv
// Shared encodings for the bounce scanner: direction, mode and FSM state.
package scanner_pkg;

   localparam logic DIR_LEFT    = 1'b0;
   localparam logic DIR_RIGHT   = 1'b1;
   localparam logic MODE_BOUNCE = 1'b0;
   localparam logic MODE_WRAP   = 1'b1;

   localparam int DWELL_W = 8;

   typedef enum logic [1:0] {
      S_RIGHT = 2'd0,
      S_LEFT  = 2'd1,
      S_DWELL = 2'd2
   } state_t;

   // Run state that moves the pointer in direction d.
   function automatic state_t run_state(input logic d);
      return (d == DIR_RIGHT) ? S_RIGHT : S_LEFT;
   endfunction

endpackage

// File: rtl/bounce_scanner_onehot_dec.sv
// Combinational index-to-one-hot decoder used to drive the LED bar.
module onehot_dec #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [W-1:0] idx,
   output logic [N-1:0] onehot
);

   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/bounce_scanner.sv
// One-hot LED pointer sweeping between runtime bounds in bounce or wrap mode.
// Optional macro SCANNER_TRAIL_EN adds a second LED showing the previous position.
module bounce_scanner
   import scanner_pkg::*;
#(
   parameter  int N_LEDS = 8,
   parameter  int DWELL  = 0,
   localparam int POS_W  = $clog2(N_LEDS)
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              en,
   input  logic              hold,
   input  logic              mode,
   input  logic [POS_W-1:0]  lo,
   input  logic [POS_W-1:0]  hi,
   output logic [POS_W-1:0]  pos,
   output logic              dir,
   output logic [N_LEDS-1:0] led,
   output logic              end_pulse,
   output logic [1:0]        fsm_state
);

   state_t             state, state_nxt;
   logic [POS_W-1:0]   pos_nxt, pos_inc, pos_dec;
   logic               dir_nxt, pulse_nxt;
   logic [DWELL_W-1:0] dwell_cnt, cnt_nxt;
   logic [N_LEDS-1:0]  led_cur;

`ifdef SCANNER_TRAIL_EN
   logic [POS_W-1:0]  prev_pos, prev_nxt;
   logic [N_LEDS-1:0] led_prev;
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state     <= S_RIGHT;
         pos       <= '0;
         dir       <= DIR_RIGHT;
         dwell_cnt <= '0;
         end_pulse <= 1'b0;
`ifdef SCANNER_TRAIL_EN
         prev_pos  <= '0;
`endif
      end else begin
         state     <= state_nxt;
         pos       <= pos_nxt;
         dir       <= dir_nxt;
         dwell_cnt <= cnt_nxt;
         end_pulse <= pulse_nxt;
`ifdef SCANNER_TRAIL_EN
         prev_pos  <= prev_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      dir_nxt   = dir;
      cnt_nxt   = dwell_cnt;
      pulse_nxt = 1'b0;
      pos_inc   = pos + POS_W'(1);
      pos_dec   = pos - POS_W'(1);
`ifdef SCANNER_TRAIL_EN
      prev_nxt  = prev_pos;
`endif
      if (en && !hold) begin
         if (lo >= hi) begin
            // Degenerate window: park on lo, keep direction and phase.
            pos_nxt = lo;
`ifdef SCANNER_TRAIL_EN
            prev_nxt = lo;
`endif
         end else if (pos < lo || pos > hi) begin
            pos_nxt   = lo;
            dir_nxt   = DIR_RIGHT;
            state_nxt = S_RIGHT;
            cnt_nxt   = '0;
`ifdef SCANNER_TRAIL_EN
            prev_nxt  = lo;
`endif
         end else begin
            case (state)
               S_DWELL: begin
                  if (dwell_cnt == DWELL_W'(DWELL)) begin
                     cnt_nxt   = '0;
                     state_nxt = run_state(dir);
                  end else begin
                     cnt_nxt = dwell_cnt + DWELL_W'(1);
                  end
               end
               S_RIGHT: begin
`ifdef SCANNER_TRAIL_EN
                  prev_nxt = pos;
`endif
                  if (pos < hi) begin
                     pos_nxt = pos_inc;
                     if (pos_inc == hi) begin
                        pulse_nxt = 1'b1;
                        if (mode == MODE_BOUNCE) dir_nxt = DIR_LEFT;
                     end
                  end else begin
                     pos_nxt   = lo;
                     pulse_nxt = 1'b1;
                  end
                  state_nxt = (pulse_nxt && DWELL > 0) ? S_DWELL : run_state(dir_nxt);
               end
               S_LEFT: begin
`ifdef SCANNER_TRAIL_EN
                  prev_nxt = pos;
`endif
                  if (pos > lo) begin
                     pos_nxt = pos_dec;
                     if (pos_dec == lo) begin
                        pulse_nxt = 1'b1;
                        if (mode == MODE_BOUNCE) dir_nxt = DIR_RIGHT;
                     end
                  end else begin
                     pos_nxt   = hi;
                     pulse_nxt = 1'b1;
                  end
                  state_nxt = (pulse_nxt && DWELL > 0) ? S_DWELL : run_state(dir_nxt);
               end
               default: state_nxt = S_RIGHT;
            endcase
         end
      end
   end

   onehot_dec #(.N(N_LEDS)) u_dec_pos (.idx(pos), .onehot(led_cur));
`ifdef SCANNER_TRAIL_EN
   onehot_dec #(.N(N_LEDS)) u_dec_prev (.idx(prev_pos), .onehot(led_prev));
`endif

   always_comb begin
`ifdef SCANNER_TRAIL_EN
      led = led_cur | led_prev;
`else
      led = led_cur;
`endif
      fsm_state = state;
   end

endmodule
